// File: rtl/out_change_capture.sv
// Result-capture FIFO: queues in_data samples, drains over valid/ready, counts overflow drops.
// Optional macro CAPTURE_CHANGE_FILTER_EN: queue only samples that differ from the previous one.
module out_change_capture #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  count,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              overflow,
    input  logic              ovf_clr
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;
    logic              accept, qual, pop, push, drop, full;

`ifdef CAPTURE_CHANGE_FILTER_EN
    logic [DATA_W-1:0] last_seen_q;
    logic              seen_any_q;

    assign accept = !seen_any_q || (in_data != last_seen_q);

    // Tracks every valid sample, even those dropped or filtered, so the filter sees true changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_seen_q <= '0;
            seen_any_q  <= 1'b0;
        end else if (in_valid) begin
            last_seen_q <= in_data;
            seen_any_q  <= 1'b1;
        end
    end
`else
    assign accept = 1'b1;
`endif

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;

        qual = in_valid && accept;
        pop  = out_valid && out_ready;
        full = (count_q == OCC_W'(DEPTH));
        push = qual && (!full || pop);
        drop = qual && full && !pop;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + CNT_W'(1);

        // A drop in the same cycle as a clear request keeps the flag set.
        if (drop)         overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is reset because out_data must read 0 after reset; the array is small.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_out_change_capture.sv
// Directed bench for out_change_capture; expectations adapt to CAPTURE_CHANGE_FILTER_EN.
module tb_out_change_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic [15:0] drop_cnt;
    logic        overflow;
    logic        ovf_clr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    out_change_capture dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

`ifdef CAPTURE_CHANGE_FILTER_EN
    localparam int N_T1 = 2;
    logic [31:0] exp_t1 [5] = '{32'd0, 32'd8, 32'd0, 32'd0, 32'd0};
`else
    localparam int N_T1 = 5;
    logic [31:0] exp_t1 [5] = '{32'd0, 32'd0, 32'd8, 32'd8, 32'd8};
`endif
    logic [31:0] stim_t1 [5] = '{32'd0, 32'd0, 32'd8, 32'd8, 32'd8};

    initial begin
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        #3 reset = 1'b1;
        step();

        // Repeated values: filtered or all queued depending on build.
        for (int i = 0; i < 5; i++) push(stim_t1[i]);
        check("t1_count", 32'(count), 32'(N_T1));
        for (int i = 0; i < N_T1; i++) pop_check($sformatf("t1_pop%0d", i), exp_t1[i]);
        check("t1_empty", 32'(out_valid), 32'd0);

        // Nine distinct words into an eight-deep FIFO: one drop.
        for (int i = 1; i <= 9; i++) push(32'(i));
        check("t3_count", 32'(count), 32'd8);
        check("t3_drop", 32'(drop_cnt), 32'd1);
        check("t3_ovf", 32'(overflow), 32'd1);
        check("t3_head", out_data, 32'd1);

        // Full with simultaneous pop and push: no drop, head advances.
        out_ready = 1'b1;
        push(32'h100);
        out_ready = 1'b0;
        check("t4_count", 32'(count), 32'd8);
        check("t4_drop", 32'(drop_cnt), 32'd1);
        check("t4_head", out_data, 32'd2);

        // Drop coincident with clear: set wins; clear alone then takes effect.
        ovf_clr = 1'b1;
        push(32'h101);
        ovf_clr = 1'b0;
        check("t5_ovf_set", 32'(overflow), 32'd1);
        check("t5_drop", 32'(drop_cnt), 32'd2);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t5_ovf_clr", 32'(overflow), 32'd0);
        check("t5_drop_kept", 32'(drop_cnt), 32'd2);

        for (int i = 2; i <= 8; i++) pop_check($sformatf("t3_pop%0d", i), 32'(i));
        pop_check("t4_pop_new", 32'h100);
        check("t3_empty", 32'(out_valid), 32'd0);
        check("t3_count0", 32'(count), 32'd0);

        // Empty with push and pop request together: pop ignored.
        out_ready = 1'b1;
        push(32'h55);
        out_ready = 1'b0;
        check("emp_pp_count", 32'(count), 32'd1);
        pop_check("emp_pp_pop", 32'h55);

        // Mid-cycle asynchronous reset with five entries queued.
        for (int i = 0; i < 5; i++) push(32'h200 + 32'(i));
        check("t6_count5", 32'(count), 32'd5);
        #2 reset = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_drop", 32'(drop_cnt), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_data", out_data, 32'd0);
        #1 reset = 1'b1;
        step();
        push(32'hABCD);
        check("t6_post_count", 32'(count), 32'd1);
        pop_check("t6_post_pop", 32'hABCD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
